// File: rtl/vn_mem_arbiter_if.sv
// Bus bundle for vn_mem_arbiter: fetch port, data port, memory port and status.
// The perf-counter outputs only exist when VN_ARB_PERF_CNT_EN is defined.
interface vn_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req_valid;
  logic              dm_req_ready;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_rsp_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;
`ifdef VN_ARB_PERF_CNT_EN
  logic [15:0]       fetch_grant_cnt;
  logic [15:0]       data_grant_cnt;
  logic [15:0]       fetch_stall_cnt;
`endif

  // Arbiter side
  modport slave (
    input  if_req_valid, if_addr, dm_req_valid, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rdata, dm_req_ready, dm_rsp_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy, owner
`ifdef VN_ARB_PERF_CNT_EN
           , fetch_grant_cnt, data_grant_cnt, fetch_stall_cnt
`endif
  );

  // Datapath / memory-model side
  modport master (
    output if_req_valid, if_addr, dm_req_valid, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rdata, dm_req_ready, dm_rsp_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy, owner
`ifdef VN_ARB_PERF_CNT_EN
           , fetch_grant_cnt, data_grant_cnt, fetch_stall_cnt
`endif
  );
endinterface

// File: rtl/vn_mem_arbiter.sv
// Unified-memory arbiter: serialises instruction fetch and load/store accesses,
// one transaction at a time, with bounded fetch starvation.
// Optional performance counters: define VN_ARB_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for a request; arbitration winner sees ready
// ACCESS | mem_en pulsed on entry, waiting MEM_LAT cycles for read data
// RESP   | response pulse delivered to the owner
module vn_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             halt,
  vn_mem_arbiter_if.slave  bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] STARVE_SAT = CNT_W'(STARVE_MAX);

  logic [1:0]        r_state;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_owner;
  logic              r_we;
  logic              r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_rsp_valid;
  logic              r_dm_rsp_valid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic w_idle;
  logic w_fetch_pend;
  logic w_fetch_win;
  logic w_data_win;

  // Ready is gated by reset so nothing is granted while reset is held.
  assign w_idle       = (r_state == S_IDLE) && reset;
  assign w_fetch_pend = bus.if_req_valid && !halt;
  assign w_fetch_win  = w_idle && w_fetch_pend &&
                        (!bus.dm_req_valid || (r_starve_cnt == STARVE_SAT));
  assign w_data_win   = w_idle && bus.dm_req_valid && !w_fetch_win;

  assign bus.if_req_ready = w_fetch_win;
  assign bus.dm_req_ready = w_data_win;
  assign bus.if_rsp_valid = r_if_rsp_valid;
  assign bus.if_rdata     = r_if_rdata;
  assign bus.dm_rsp_valid = r_dm_rsp_valid;
  assign bus.dm_rdata     = r_dm_rdata;
  assign bus.mem_en       = r_mem_en;
  assign bus.mem_we       = r_mem_en && r_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.owner        = r_owner;

  // Transaction sequencer: accept, strobe memory, wait latency, respond.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_lat_cnt      <= '0;
      r_owner        <= 1'b0;
      r_we           <= 1'b0;
      r_mem_en       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_if_rsp_valid <= 1'b0;
      r_dm_rsp_valid <= 1'b0;
      r_if_rdata     <= '0;
      r_dm_rdata     <= '0;
    end else begin
      r_mem_en       <= 1'b0;
      r_if_rsp_valid <= 1'b0;
      r_dm_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fetch_win) begin
            r_state    <= S_ACCESS;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_mem_addr <= bus.if_addr;
            r_mem_en   <= 1'b1;
            r_lat_cnt  <= LAT_LOAD;
          end else if (w_data_win) begin
            r_state     <= S_ACCESS;
            r_owner     <= 1'b1;
            r_we        <= bus.dm_we;
            r_mem_addr  <= bus.dm_addr;
            r_mem_wdata <= bus.dm_wdata;
            r_mem_en    <= 1'b1;
            r_lat_cnt   <= LAT_LOAD;
          end
        end
        S_ACCESS: begin
          if (r_lat_cnt == '0) begin
            r_state <= S_RESP;
            if (!r_owner) begin
              r_if_rsp_valid <= 1'b1;
              r_if_rdata     <= bus.mem_rdata;
            end else begin
              r_dm_rsp_valid <= 1'b1;
              if (!r_we) r_dm_rdata <= bus.mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Starvation counter: data grants while a fetch waits, saturating.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (w_fetch_win) begin
      r_starve_cnt <= '0;
    end else if (w_data_win && w_fetch_pend) begin
      if (r_starve_cnt != STARVE_SAT) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end else if (w_idle && !w_fetch_pend) begin
      r_starve_cnt <= '0;
    end
  end

`ifdef VN_ARB_PERF_CNT_EN
  logic [15:0] r_fetch_grant_cnt;
  logic [15:0] r_data_grant_cnt;
  logic [15:0] r_fetch_stall_cnt;

  assign bus.fetch_grant_cnt = r_fetch_grant_cnt;
  assign bus.data_grant_cnt  = r_data_grant_cnt;
  assign bus.fetch_stall_cnt = r_fetch_stall_cnt;

  // Wrap-around grant and fetch-stall counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fetch_grant_cnt <= '0;
      r_data_grant_cnt  <= '0;
      r_fetch_stall_cnt <= '0;
    end else begin
      if (w_fetch_win) r_fetch_grant_cnt <= r_fetch_grant_cnt + 16'd1;
      if (w_data_win)  r_data_grant_cnt  <= r_data_grant_cnt + 16'd1;
      if (w_fetch_pend && !w_fetch_win) r_fetch_stall_cnt <= r_fetch_stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: doc/vn_mem_arbiter.md
Name: vn_mem_arbiter

Overview:
Arbiter and sequencer for the single unified memory of the Von Neumann CPU. The instruction-fetch path and the load/store data path share this memory, and the block serialises their accesses.
- Accepts requests over valid/ready handshakes and drives one memory transaction at a time.
- Returns read data with a one-cycle response pulse.
- Honours a halt input from the control unit (HLT).
- Sits between the datapath (PC/IR fetch, load/store unit) and the memory model.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 16, memory word width
MEM_LAT, 1, cycles from mem_en to mem_rdata valid (>=1)
STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
halt  in  1  1 = block new fetch grants
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted this cycle
if_addr  in  ADDR_W  fetch address (PC)
if_rsp_valid  out  1  one-cycle fetch response pulse
if_rdata  out  DATA_W  fetched instruction word
dm_req_valid  in  1  data request
dm_req_ready  out  1  data request accepted this cycle
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rsp_valid  out  1  one-cycle completion pulse (loads and stores)
dm_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  transaction in flight (state != IDLE)
owner  out  1  0 = fetch, 1 = data; owner of current or last transaction

Behaviour:
- All state changes occur on the rising edge of clock. reset==0 at an edge clears everything.
- Reset values: every registered output is 0, FSM = IDLE, starve counter = 0.
- The FSM has three states: IDLE, ACCESS and RESP.
- IDLE, ready outputs (combinational):
  - Only the arbitration winner sees ready=1. Both ready outputs are 0 outside IDLE.
- IDLE, arbitration:
  - Data wins by default.
  - Fetch wins if data is not valid, or if starve_cnt == STARVE_MAX and if_req_valid is 1.
- IDLE, halt:
  - halt==1 masks fetch: if_req_ready=0, and fetch does not count as pending.
  - Data is unaffected by halt.
- Accept cycle T (valid&&ready): latch addr, we and wdata, plus owner. Next state is ACCESS.
- ACCESS:
  - mem_en=1 for exactly cycle T+1, with mem_addr/mem_wdata/mem_we from the latched values.
  - mem_we=0 for fetches.
  - A latency counter loads MEM_LAT. At cycle T+1+MEM_LAT, mem_rdata is captured, then next state is RESP.
- RESP:
  - In cycle T+2+MEM_LAT the owner's rsp_valid=1 for one cycle.
  - if_rdata or dm_rdata (load only) takes the captured value and holds it until that owner's next load/fetch response.
  - A store leaves dm_rdata unchanged.
  - Next state is IDLE. New accepts happen in IDLE only, so throughput is one transaction per MEM_LAT+3 cycles minimum.
- mem_addr/mem_wdata hold their last value when mem_en=0.
- starve_cnt:
  - +1 on each data grant while a fetch is pending (if_req_valid && !halt), saturating at STARVE_MAX.
  - Cleared on a fetch grant, and in IDLE when no fetch is pending.
- Simultaneous events:
  - halt rising during an in-flight fetch: the fetch completes and the response is delivered.
  - Request inputs changing while not ready are ignored.
- Reset mid-operation: the in-flight transaction is dropped, no rsp_valid pulse is issued, and mem_en is 0 from the next cycle.
- busy=1 in ACCESS and RESP.

Optional Feature:
- Macro: VN_ARB_PERF_CNT_EN.
- When defined, three extra 16-bit outputs are added, each wrap-around and cleared by reset:
  - fetch_grant_cnt: fetch accepts.
  - data_grant_cnt: data accepts.
  - fetch_stall_cnt: cycles with if_req_valid && !halt && !if_req_ready.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. reset=0 for 3 cycles with both valids=1 → all outputs 0, no ready. Release reset → first accept is data (owner=1).
2. MEM_LAT=1, single fetch if_addr=0x10, memory returns 0xABCD → accept at T, mem_en=1 with mem_addr=0x10 at T+1, if_rsp_valid=1 with if_rdata=0xABCD at T+3 only.
3. Both valids held high, STARVE_MAX=4 → grant order D,D,D,D,F,D,D,D,D,F.
4. halt=1, fetch pending, store dm_addr=0x20 dm_wdata=0x1234 → mem_we=1, mem_addr=0x20, mem_wdata=0x1234, dm_rsp_valid pulse, dm_rdata unchanged, no if_req_ready. Drop halt → fetch accepted on the next IDLE cycle.
5. reset=0 during ACCESS with MEM_LAT=3 → no rsp_valid; busy=0 and mem_en=0 the next cycle.
6. With VN_ARB_PERF_CNT_EN, scenario 3 for 10 grants → fetch_grant_cnt=2, data_grant_cnt=8, fetch_stall_cnt>0.
